// File: rtl/datapath_sequencer_pkg.sv
// rtl/datapath_sequencer_pkg.sv - shared codes, opcodes, ALU ops and states for the sequencer
//
// Purpose: single source of truth for the Datapath register/source codes, the IR opcode
// values, the ALU control values and the sequencer state encoding.
// Ports: none (package).

package datapath_sequencer_pkg;

  // Control steps: fetch is T0-T2, execute is T3-T5.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALTED
  } state_t;

  // Register / bus source codes (R0-R15 are codes 0-15).
  localparam logic [4:0] CODE_ZLO = 5'd19;
  localparam logic [4:0] CODE_PC  = 5'd20;
  localparam logic [4:0] CODE_MDR = 5'd21;
  localparam logic [4:0] CODE_IR  = 5'd23;
  localparam logic [4:0] CODE_Z   = 5'd24;
  localparam logic [4:0] CODE_MAR = 5'd25;
  localparam logic [4:0] CODE_Y   = 5'd27;

  // IR opcode field values.
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  // ALU control values driven on Control_Signals.
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;

  // Turns a 5-bit register/source code into its one-hot enable/select bit.
  function automatic logic [31:0] onehot32(input logic [4:0] code);
    return 32'd1 << code;
  endfunction

endpackage

// File: rtl/datapath_op_decode.sv
// rtl/datapath_op_decode.sv - combinational opcode decoder for the sequencer
//
// Purpose: maps the IR opcode field to an ALU control value and classifies it.
// Ports:
//   opcode_i  in  5  IR[31:27]
//   alu_op_o  out 4  ALU control value (ALU_NONE when not an ALU instruction)
//   legal_o   out 1  opcode is a 3-register ALU instruction
//   halt_o    out 1  opcode is HALT

module datapath_op_decode
  import datapath_sequencer_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic [3:0] alu_op_o,
  output logic       legal_o,
  output logic       halt_o
);

  always_comb begin
    alu_op_o = ALU_NONE;
    legal_o  = 1'b1;
    halt_o   = 1'b0;
    unique case (opcode_i)
      OP_ADD:  alu_op_o = ALU_ADD;
      OP_SUB:  alu_op_o = ALU_SUB;
      OP_AND:  alu_op_o = ALU_AND;
      OP_OR:   alu_op_o = ALU_OR;
      OP_SHR:  alu_op_o = ALU_SHR;
      OP_SHL:  alu_op_o = ALU_SHL;
      OP_HALT: begin
        legal_o = 1'b0;
        halt_o  = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - hardwired fetch/execute control-step sequencer for the Datapath
//
// Purpose: steps T0-T5 for 3-register ALU instructions and drives the Datapath controls.
// Ports:
//   clk             in   1      rising-edge clock
//   clr             in   1      asynchronous active-low reset
//   run             in   1      start/continue sequencing from IDLE
//   ir              in   32     IR contents, valid from T3
//   mem_ready       in   1      memory data valid on MDataIn
//   enable          out  32     one-hot register load enables
//   busSelect       out  32     one-hot bus source select (0 = idle bus)
//   MR_Read         out  1      MDR loads from MDataIn
//   inc_pc          out  1      PC loads PC+1
//   Control_Signals out  4      ALU op
//   busy            out  1      sequencing an instruction
//   illegal         out  1      undecodable opcode seen in T3
//   mem_err         out  1      T1 memory wait timed out
//   instr_count     out  CNT_W  retired instruction count (wraps)

module datapath_sequencer
  import datapath_sequencer_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             run,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [31:0]      enable,
  output logic [31:0]      busSelect,
  output logic             MR_Read,
  output logic             inc_pc,
  output logic [3:0]       Control_Signals,
  output logic             busy,
  output logic             illegal,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  // wait_cnt counts T1 cycles already spent without ready: 0 .. WAIT_MAX-1.
  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;

  logic [3:0] alu_op;
  logic       op_legal;
  logic       op_halt;
  logic       unused_ir;

  assign unused_ir = ^ir[14:0];

  datapath_op_decode u_decode (
    .opcode_i (ir[31:27]),
    .alu_op_o (alu_op),
    .legal_o  (op_legal),
    .halt_o   (op_halt)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    instr_cnt_d     = instr_cnt_q;
    enable          = '0;
    busSelect       = '0;
    MR_Read         = 1'b0;
    inc_pc          = 1'b0;
    Control_Signals = ALU_NONE;
    illegal         = 1'b0;
    mem_err         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_T0;
      end
      ST_T0: begin
        busSelect  = onehot32(CODE_PC);
        enable     = onehot32(CODE_MAR) | onehot32(CODE_PC);
        inc_pc     = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_T1;
      end
      ST_T1: begin
        MR_Read = 1'b1;
        enable  = onehot32(CODE_MDR);
        if (mem_ready) begin
          state_d = ST_T2;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Last permitted wait cycle passed without data: abandon the fetch.
          mem_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_T2: begin
        busSelect = onehot32(CODE_MDR);
        enable    = onehot32(CODE_IR);
        state_d   = ST_T3;
      end
      ST_T3: begin
        busSelect = onehot32({1'b0, ir[22:19]});
        if (op_halt) begin
          state_d = ST_HALTED;
        end else if (!op_legal) begin
          illegal = 1'b1;
          state_d = run ? ST_T0 : ST_IDLE;
        end else begin
          enable  = onehot32(CODE_Y);
          state_d = ST_T4;
        end
      end
      ST_T4: begin
        busSelect       = onehot32({1'b0, ir[18:15]});
        enable          = onehot32(CODE_Z);
        Control_Signals = alu_op;
        state_d         = ST_T5;
      end
      ST_T5: begin
        busSelect   = onehot32(CODE_ZLO);
        enable      = onehot32({1'b0, ir[26:23]});
        instr_cnt_d = instr_cnt_q + 1'b1;
        state_d     = run ? ST_T0 : ST_IDLE;
      end
      ST_HALTED: begin
        // Sticky until reset; run is ignored.
        state_d = ST_HALTED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign instr_count = instr_cnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - self-checking bench for datapath_sequencer

module tb_datapath_sequencer;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 16;
  localparam int PH_IDLE  = 7;

  logic        clk = 1'b0;
  logic        clr;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic        MR_Read;
  logic        inc_pc;
  logic [3:0]  Control_Signals;
  logic        busy;
  logic        illegal;
  logic        mem_err;
  logic [CNT_W-1:0] instr_count;

  int vectors = 0;
  int errors  = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  datapath_sequencer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .clr             (clr),
    .run             (run),
    .ir              (ir),
    .mem_ready       (mem_ready),
    .enable          (enable),
    .busSelect       (busSelect),
    .MR_Read         (MR_Read),
    .inc_pc          (inc_pc),
    .Control_Signals (Control_Signals),
    .busy            (busy),
    .illegal         (illegal),
    .mem_err         (mem_err),
    .instr_count     (instr_count)
  );

  // {count, enable, busSelect, MR_Read, inc_pc, Control_Signals, busy, illegal, mem_err}
  function automatic logic [88:0] observe();
    return {instr_count, enable, busSelect, MR_Read, inc_pc, Control_Signals,
            busy, illegal, mem_err};
  endfunction

  // Expected outputs for control step `phase` of instruction iv, from the step table.
  function automatic logic [88:0] expect_out(input int phase, input logic [31:0] iv);
    logic [31:0] en, bs;
    logic        mr, inc, bz, ill;
    logic [3:0]  cs;
    int          opc;
    en = '0; bs = '0; mr = 1'b0; inc = 1'b0; cs = '0; bz = 1'b1; ill = 1'b0;
    opc = int'(iv[31:27]);
    case (phase)
      0: begin bs = 32'd1 << 20; en = (32'd1 << 25) | (32'd1 << 20); inc = 1'b1; end
      1: begin mr = 1'b1; en = 32'd1 << 21; end
      2: begin bs = 32'd1 << 21; en = 32'd1 << 23; end
      3: begin
        bs = 32'd1 << iv[22:19];
        if (opc >= 3 && opc <= 8) en = 32'd1 << 27;
        else if (opc != 31) ill = 1'b1;
      end
      4: begin bs = 32'd1 << iv[18:15]; en = 32'd1 << 24; cs = 4'(opc - 2); end
      5: begin bs = 32'd1 << 19; en = 32'd1 << iv[26:23]; end
      default: bz = 1'b0;
    endcase
    return {CNT_W'(exp_count), en, bs, mr, inc, cs, bz, ill, 1'b0};
  endfunction

  function automatic logic [31:0] rand_alu();
    logic [4:0] opc;
    opc = 5'(3 + $urandom_range(0, 5));
    return {opc, 27'($urandom)};
  endfunction

  // One cycle in IDLE (or HALTED): all outputs zero.
  task automatic idle_cycles(input string tag, input int n, input logic run_v);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      run = run_v; mem_ready = 1'($urandom); ir = $urandom;
      #1; vectors++;
      if (observe() !== expect_out(PH_IDLE, 32'd0)) begin
        errors++;
        $display("FAIL %s idle cycle %0d: got %h want %h", tag, k, observe(),
                 expect_out(PH_IDLE, 32'd0));
      end
    end
  endtask

  // Raises run from IDLE; the cycle after this one is T0.
  task automatic start_from_idle(input string tag);
    idle_cycles(tag, 1, 1'b1);
  endtask

  // Walks one instruction starting in T0, checking every step up to stop_at.
  // run is held 1 in T0/T1 and set to run_end from T2 on.
  task automatic exec_instr(input string tag, input logic [31:0] iv, input int delay,
                            input logic run_end, input int stop_at);
    int last, reps, opc;
    opc  = int'(iv[31:27]);
    last = (opc >= 3 && opc <= 8) ? 5 : 3;
    if (stop_at < last) last = stop_at;
    for (int p = 0; p <= last; p++) begin
      reps = (p == 1) ? delay + 1 : 1;
      for (int j = 0; j < reps; j++) begin
        @(negedge clk);
        run       = (p >= 2) ? run_end : 1'b1;
        ir        = (p >= 3) ? iv : $urandom;
        mem_ready = (p == 1) ? (j == delay) : 1'($urandom);
        #1; vectors++;
        if (observe() !== expect_out(p, iv)) begin
          errors++;
          $display("FAIL %s ir=%h T%0d wait%0d: got %h want %h", tag, iv, p, j,
                   observe(), expect_out(p, iv));
        end
      end
    end
    if (last == 5) exp_count++;
  endtask

  task automatic test_reset();
    clr = 1'b0; run = 1'b0; ir = '0; mem_ready = 1'b0;
    #2; vectors++;
    if (observe() !== expect_out(PH_IDLE, 32'd0)) begin
      errors++;
      $display("FAIL reset: got %h want %h", observe(), expect_out(PH_IDLE, 32'd0));
    end
    idle_cycles("reset_hold", 3, 1'b1);
    @(negedge clk);
    clr = 1'b1; run = 1'b0;
    idle_cycles("reset_release", 2, 1'b0);
  endtask

  task automatic test_add();
    start_from_idle("add");
    exec_instr("add", 32'h18A28000, 0, 1'b0, 5);
    idle_cycles("add_after", 2, 1'b0);
  endtask

  task automatic test_random_instr();
    logic [31:0] iv;
    int d;
    start_from_idle("rand");
    for (int i = 0; i < 12; i++) begin
      iv = rand_alu();
      d  = (i == 0) ? WAIT_MAX - 1 : $urandom_range(0, 4);
      exec_instr("rand", iv, d, (i != 11), 5);
    end
    idle_cycles("rand_after", 1, 1'b0);
  endtask

  task automatic test_mem_timeout();
    logic [88:0] want;
    start_from_idle("timeout");
    exec_instr("timeout", rand_alu(), 0, 1'b1, 0);
    for (int j = 0; j < WAIT_MAX; j++) begin
      @(negedge clk);
      mem_ready = 1'b0; run = 1'b1;
      #1; vectors++;
      want = expect_out(1, 32'd0) | 89'(j == WAIT_MAX - 1);
      if (observe() !== want) begin
        errors++;
        $display("FAIL timeout wait%0d: got %h want %h", j, observe(), want);
      end
    end
    idle_cycles("timeout_after", 2, 1'b0);
  endtask

  task automatic test_illegal();
    logic [31:0] iv;
    logic [4:0]  bad [3] = '{5'b01111, 5'b00000, 5'b10010};
    start_from_idle("illegal");
    for (int i = 0; i < 3; i++) begin
      iv = {bad[i], 27'($urandom)};
      exec_instr("illegal", iv, i, 1'b1, 5);
    end
    exec_instr("illegal_next", rand_alu(), 0, 1'b0, 5);
    idle_cycles("illegal_after", 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_from_idle("b2b");
    for (int i = 0; i < 4; i++) exec_instr("b2b", rand_alu(), 0, (i != 3), 5);
    idle_cycles("b2b_after", 1, 1'b0);
  endtask

  task automatic test_run_drop();
    start_from_idle("run_drop");
    exec_instr("run_drop", rand_alu(), 1, 1'b0, 5);
    idle_cycles("run_drop_after", 3, 1'b0);
  endtask

  task automatic test_clr_mid();
    start_from_idle("clr_mid");
    exec_instr("clr_mid", rand_alu(), 0, 1'b1, 4);
    #2 clr = 1'b0;
    #1; vectors++;
    exp_count = 0;
    if (observe() !== expect_out(PH_IDLE, 32'd0)) begin
      errors++;
      $display("FAIL clr_mid async: got %h want %h", observe(), expect_out(PH_IDLE, 32'd0));
    end
    idle_cycles("clr_mid_hold", 1, 1'b1);
    @(negedge clk);
    clr = 1'b1; run = 1'b1;
    #1; vectors++;
    if (observe() !== expect_out(PH_IDLE, 32'd0)) begin
      errors++;
      $display("FAIL clr_mid release: got %h want %h", observe(), expect_out(PH_IDLE, 32'd0));
    end
    exec_instr("clr_mid_restart", rand_alu(), 0, 1'b0, 5);
    idle_cycles("clr_mid_after", 1, 1'b0);
  endtask

  task automatic test_halt();
    start_from_idle("halt");
    exec_instr("halt", {5'b11111, 27'($urandom)}, 0, 1'b1, 5);
    idle_cycles("halted", 20, 1'b1);
    @(negedge clk);
    clr = 1'b0;
    #1; exp_count = 0;
    @(negedge clk);
    clr = 1'b1; run = 1'b1;
    exec_instr("halt_restart", rand_alu(), 0, 1'b0, 5);
    idle_cycles("halt_after", 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_random_instr();
    test_mem_timeout();
    test_illegal();
    test_back_to_back();
    test_run_drop();
    test_clr_mid();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
